// File: rtl/seq_divider_n.sv
// Restoring divider: one quotient bit per clock, optional two's-complement mode.
// Fixed WIDTH+1 cycle latency from accept; starts arriving while busy are dropped.
module seq_divider_n #(
    parameter int WIDTH     = 8,
    parameter bit SIGNED_EN = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             div_start,
    input  logic             signed_mode,
    input  logic [WIDTH-1:0] divident,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             div_ready,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);
    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_FIX
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_raw_dvd;
    logic [WIDTH-1:0] r_dvd_q;
    logic [WIDTH-1:0] r_dvs;
    logic [WIDTH-1:0] r_rem;
    logic             r_neg_q;
    logic             r_neg_r;
    logic             r_dz;
    logic             r_ready;

    logic             w_accept;
    logic             w_signed_op;
    logic             w_qbit;
    logic [WIDTH-1:0] w_dvd_abs;
    logic [WIDTH-1:0] w_dvs_abs;
    logic [WIDTH-1:0] w_rem_nxt;
    logic [WIDTH:0]   w_trial;
    logic [WIDTH:0]   w_diff;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (div_start) begin
                    w_accept    = 1'b1;
                    w_state_nxt = S_CALC;
                end
            end
            S_CALC: begin
                if (r_cnt == '0) begin
                    w_state_nxt = S_FIX;
                end
            end
            S_FIX:   w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign w_signed_op = SIGNED_EN && signed_mode;
    assign w_dvd_abs   = (w_signed_op && divident[WIDTH-1]) ? -divident : divident;
    assign w_dvs_abs   = (w_signed_op && divisor[WIDTH-1])  ? -divisor  : divisor;

    // Partial remainder is widened by one bit so the trial subtract never overflows;
    // the borrow out of that extra bit is the inverted quotient bit.
    assign w_trial   = {r_rem, r_dvd_q[WIDTH-1]};
    assign w_diff    = w_trial - {1'b0, r_dvs};
    assign w_qbit    = ~w_diff[WIDTH];
    assign w_rem_nxt = w_qbit ? w_diff[WIDTH-1:0] : w_trial[WIDTH-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt       <= '0;
            r_raw_dvd   <= '0;
            r_dvd_q     <= '0;
            r_dvs       <= '0;
            r_rem       <= '0;
            r_neg_q     <= 1'b0;
            r_neg_r     <= 1'b0;
            r_dz        <= 1'b0;
            r_ready     <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            r_ready <= 1'b0;
            if (w_accept) begin
                r_raw_dvd <= divident;
                r_dvd_q   <= w_dvd_abs;
                r_dvs     <= w_dvs_abs;
                r_rem     <= '0;
                r_neg_q   <= w_signed_op && (divident[WIDTH-1] ^ divisor[WIDTH-1]);
                r_neg_r   <= w_signed_op && divident[WIDTH-1];
                r_dz      <= (divisor == '0);
                r_cnt     <= CW'(WIDTH - 1);
            end else if (r_state == S_CALC) begin
                // Dividend register doubles as the quotient shift register.
                r_rem   <= w_rem_nxt;
                r_dvd_q <= {r_dvd_q[WIDTH-2:0], w_qbit};
                r_cnt   <= r_cnt - CW'(1);
            end else if (r_state == S_FIX) begin
                quotient    <= r_dz ? '1 : (r_neg_q ? -r_dvd_q : r_dvd_q);
                remainder   <= r_dz ? r_raw_dvd : (r_neg_r ? -r_rem : r_rem);
                div_by_zero <= r_dz;
                r_ready     <= 1'b1;
            end
        end
    end

    assign busy      = (r_state != S_IDLE);
    assign div_ready = r_ready;

endmodule
